// File: rtl/byte_ram_responder.sv
// Byte-wide RAM responder for the CPU memory bus: two-cycle pipelined reads with
// same-cycle write forwarding, optional clear-after-reset, and LED/button I/O bytes.
module byte_ram_responder #(
   parameter int addr_width     = 9,
   parameter bit clear_on_reset = 1'b0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [addr_width-1:0] mem_raddr,
   input  logic [addr_width-1:0] mem_waddr,
   input  logic [7:0]            mem_data_in,
   input  logic                  mem_write,
   output logic [7:0]            mem_data_out,
   output logic                  mem_ready,
   output logic [7:0]            leds,
   input  logic [3:0]            buttons
);

   localparam int                    DEPTH    = 2 ** addr_width;
   localparam logic [addr_width-1:0] LED_ADDR = addr_width'(DEPTH - 1);
   localparam logic [addr_width-1:0] BTN_ADDR = addr_width'(DEPTH - 2);

   typedef enum logic {CLEAR, READY} state_t;

   function automatic logic is_io(input logic [addr_width-1:0] a);
      return (a == LED_ADDR) || (a == BTN_ADDR);
   endfunction

   state_t                state_q, state_d;
   logic [addr_width-1:0] clr_cnt_q, clr_cnt_d;
   logic                  clr_we;

   logic [3:0]            btn_s1_q, btn_s1_d;
   logic [3:0]            btn_s2_q, btn_s2_d;
   logic [7:0]            leds_q, leds_d;

   logic                  cpu_we;
   logic                  fwd;
   logic                  ram_we;
   logic [addr_width-1:0] ram_waddr;
   logic [7:0]            ram_wdata;
   logic [7:0]            ram [DEPTH];

   logic [7:0]            ram_rdata_p1_q;
   logic                  use_ram_p1_q, use_ram_p1_d;
   logic [7:0]            io_data_p1_q, io_data_p1_d;
   logic [7:0]            mem_data_out_q, mem_data_out_d;

   // FSM: state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= CLEAR;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   // FSM: next state; without clear_on_reset CLEAR is left on the first free edge
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      case (state_q)
         CLEAR: begin
            if (!clear_on_reset) begin
               state_d = READY;
            end else begin
               clr_cnt_d = clr_cnt_q + 1'b1;
               if (clr_cnt_q == LED_ADDR) state_d = READY;
            end
         end
         READY:   state_d = READY;
         default: state_d = CLEAR;
      endcase
   end

   // FSM: outputs
   always_comb begin
      mem_ready = (state_q == READY);
      clr_we    = (state_q == CLEAR) && clear_on_reset && !reset;
   end

   // Write acceptance; reset and an unfinished clear both drop CPU writes
   always_comb begin
      cpu_we = mem_write && mem_ready && !reset;
      fwd    = cpu_we && (mem_waddr == mem_raddr) && (mem_waddr != BTN_ADDR);
      if (clr_we) begin
         ram_we    = !is_io(clr_cnt_q);
         ram_waddr = clr_cnt_q;
         ram_wdata = 8'h00;
      end else begin
         ram_we    = cpu_we && !is_io(mem_waddr);
         ram_waddr = mem_waddr;
         ram_wdata = mem_data_in;
      end
   end

   always_comb begin
      btn_s1_d = buttons;
      btn_s2_d = btn_s1_q;
      leds_d   = (cpu_we && (mem_waddr == LED_ADDR)) ? mem_data_in : leds_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         btn_s1_q <= '0;
         btn_s2_q <= '0;
         leds_q   <= '0;
      end else begin
         btn_s1_q <= btn_s1_d;
         btn_s2_q <= btn_s2_d;
         leds_q   <= leds_d;
      end
   end

   // Stage 1: synchronous RAM read, forwarded / I/O data captured alongside
   always_ff @(posedge clk) begin
      if (ram_we) ram[ram_waddr] <= ram_wdata;
      ram_rdata_p1_q <= ram[mem_raddr];
   end

   always_comb begin
      use_ram_p1_d = !fwd && !is_io(mem_raddr);
      if (fwd)                       io_data_p1_d = mem_data_in;
      else if (mem_raddr == LED_ADDR) io_data_p1_d = leds_q;
      else if (mem_raddr == BTN_ADDR) io_data_p1_d = {4'b0000, btn_s2_q};
      else                           io_data_p1_d = 8'h00;
   end

   always_ff @(posedge clk) begin
      use_ram_p1_q <= use_ram_p1_d;
      io_data_p1_q <= io_data_p1_d;
   end

   // Stage 2: output select, held at zero until the block is ready
   always_comb begin
      if (!mem_ready)        mem_data_out_d = 8'h00;
      else if (use_ram_p1_q) mem_data_out_d = ram_rdata_p1_q;
      else                   mem_data_out_d = io_data_p1_q;
   end

   always_ff @(posedge clk) begin
      if (reset) mem_data_out_q <= 8'h00;
      else       mem_data_out_q <= mem_data_out_d;
   end

   assign mem_data_out = mem_data_out_q;
   assign leds         = leds_q;

endmodule
